seq_mult_sa: RTL and testbench
==============================

Name: seq_mult_sa

Overview:
Parametrised sequential shift-and-add multiplier with a start/busy/done handshake and a registered product. It is the next generation of the team's controller-plus-datapath multiplier and replaces repeated addition (B cycles) with radix-2 shift-and-add (at most W cycles). It adds configurable width, a run-time signed/unsigned mode and optional early termination. It is a standalone arithmetic unit that other controllers start and poll.

Parameters:
W, 16, operand width in bits (W >= 2); product is 2W bits
EARLY_EXIT, 1, 1 = stop iterating once the remaining multiplier bits are all zero; 0 = always run W iterations

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
start  input  1  request; sampled only in IDLE
signed_mode  input  1  1 = a and b are two's complement; 0 = unsigned; captured with start
a  input  W  multiplicand, captured with start
b  input  W  multiplier, captured with start
busy  output  1  high while in CALC or FIN
done  output  1  one-cycle pulse; product is valid from this cycle onward
product  output  2W  result; holds until the next done

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy=0, done=0, product=0; all internal registers 0. Asserting reset mid-operation aborts the operation; no done is produced.
- Internal registers: ma (2W, shifted multiplicand), mb (W, remaining multiplier), acc (2W), cnt ($clog2(W)+1 bits), neg (1).
- IDLE:
  - start=1: ma <= |a| zero-extended; mb <= |b|; acc <= 0; cnt <= 0; neg <= signed_mode & (a[W-1]^b[W-1]); state <= CALC.
  - Absolute value applies only when signed_mode=1; otherwise the raw bits are used.
  - |-2^(W-1)| = 2^(W-1), which fits unsigned in W bits, so no overflow case exists.
- CALC, one iteration per edge:
  - if mb[0], acc <= acc + ma (2W-bit add, no carry-out possible)
  - ma <= ma<<1; mb <= mb>>1; cnt <= cnt+1
  - Leave for FIN when cnt==W-1, or (EARLY_EXIT=1 and (mb>>1)==0).
- FIN, one edge: product <= neg ? -acc : acc (two's complement, 2W bits); done <= 1; state <= IDLE.
- done is deasserted on every other edge, so it is exactly one cycle wide.
- busy is combinational from state (CALC or FIN); done is registered.
- Latency, counted in edges from the edge that samples start to the edge that raises done:
  - EARLY_EXIT=0: W+1.
  - EARLY_EXIT=1: n+1, where n = max(1, position of highest set bit of |b| + 1). b=0 gives n=1, latency 2.
- start while busy=1 is ignored; there is no queueing.
- start high in the done cycle (state is IDLE) is accepted; back-to-back throughput is latency+1 cycles per result.
- a, b and signed_mode may change freely after capture with no effect on the running operation.
- The product register is written only in FIN; it keeps its old value through the next operation's CALC.
- The mode captured at start governs the whole operation.
- Illegal state encodings recover to IDLE on the next edge with no done.

Decomposition:
- Shared package mult_pkg holds:
  - the state encoding constants IDLE=2'b00, CALC=2'b01, FIN=2'b10
  - a helper function abs_w for conditional two's-complement magnitude, parametrised by width.
- One natural sub-module: seq_mult_ctrl, the FSM plus cnt and the exit decision, producing the load/iterate/finish strobes.
- The datapath (ma, mb, acc, neg, product) stays in seq_mult_sa, mirroring the team's controller/datapath split.

Test Plan:
- W=16, EARLY_EXIT=0, unsigned, a=17, b=5 -> product=85 (0x00000055); done exactly 17 edges after start sampled; busy high for 17 cycles.
- W=16, signed, a=-3 (0xFFFD), b=7 -> product=0xFFFFFFEB (-21). Same operands with signed_mode=0 -> 0x0006FFEB.
- W=16, signed, a=b=0x8000 -> product=0x40000000. Unsigned a=b=0xFFFF -> 0xFFFE0001.
- EARLY_EXIT=1, a=1234, b=0 -> product=0, done 2 edges after start. b=5 -> done 4 edges after start, product=6170.
- start pulsed mid-CALC with different operands -> ignored, first result unchanged. start held high in the done cycle -> second operation begins, second done at the expected latency.
- rst_n pulled low asynchronously mid-CALC -> busy, done and product go to 0 immediately, no done pulse follows. After release, a=9, b=9 -> 81.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier: FSM state
// encoding and the conditional magnitude helper used when operands are captured.
package mult_pkg;

   localparam int MAX_W = 64;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      FIN  = 2'b10
   } state_t;

   // Magnitude of the low w bits of v when sgn is set; the caller truncates to w bits.
   // -2^(w-1) maps to 2^(w-1), which still fits unsigned in w bits.
   function automatic logic [MAX_W-1:0] abs_w(input logic [MAX_W-1:0] v,
                                              input int w,
                                              input logic sgn);
      if (sgn && v[6'(w-1)])
         return -v;
      else
         return v;
   endfunction

endpackage

// File: rtl/seq_mult_ctrl.sv
// Controller for seq_mult_sa: IDLE/CALC/FIN FSM, iteration counter and exit
// decision; emits load/iterate/finish strobes to the datapath.
module seq_mult_ctrl
   import mult_pkg::*;
#(
   parameter int W          = 16,
   parameter int EARLY_EXIT = 1
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   start,
   input  logic   mb_rest_zero,
   output logic   load,
   output logic   iter,
   output logic   fin,
   output state_t state_dbg
);

   localparam int CNT_W = $clog2(W) + 1;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q;
   logic               last_iter;

   // mb_rest_zero reflects the multiplier after this iteration's shift.
   assign last_iter = (cnt_q == CNT_W'(W - 1)) || ((EARLY_EXIT != 0) && mb_rest_zero);
   assign state_dbg = state_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (load)
            cnt_q <= '0;
         else if (iter)
            cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      iter    = 1'b0;
      fin     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               load    = 1'b1;
               state_d = CALC;
            end
         end
         CALC: begin
            iter = 1'b1;
            if (last_iter)
               state_d = FIN;
         end
         FIN: begin
            fin     = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: rtl/seq_mult_sa.sv
// Sequential radix-2 shift-and-add multiplier with start/busy/done handshake,
// run-time signed mode and optional early termination on an exhausted multiplier.
module seq_mult_sa
   import mult_pkg::*;
#(
   parameter int W          = 16,
   parameter int EARLY_EXIT = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic           signed_mode,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [2*W-1:0] product
);

   // Handshake: start is honoured only when busy=0 (IDLE, including the done
   // cycle); done pulses for one cycle and product holds until the next done.

   logic [2*W-1:0] ma_q, acc_q, product_q;
   logic [W-1:0]   mb_q, a_mag, b_mag;
   logic           neg_q, done_q;
   logic           load, iter, fin, mb_rest_zero;
   state_t         state_dbg;

   assign a_mag        = W'(abs_w(MAX_W'(a), W, signed_mode));
   assign b_mag        = W'(abs_w(MAX_W'(b), W, signed_mode));
   assign mb_rest_zero = (mb_q[W-1:1] == '0);

   seq_mult_ctrl #(
      .W          (W),
      .EARLY_EXIT (EARLY_EXIT)
   ) u_ctrl (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .mb_rest_zero (mb_rest_zero),
      .load         (load),
      .iter         (iter),
      .fin          (fin),
      .state_dbg    (state_dbg)
   );

   assign busy    = (state_dbg == CALC) || (state_dbg == FIN);
   assign done    = done_q;
   assign product = product_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ma_q      <= '0;
         mb_q      <= '0;
         acc_q     <= '0;
         neg_q     <= 1'b0;
         product_q <= '0;
         done_q    <= 1'b0;
      end else begin
         if (load) begin
            ma_q  <= {{W{1'b0}}, a_mag};
            mb_q  <= b_mag;
            acc_q <= '0;
            neg_q <= signed_mode & (a[W-1] ^ b[W-1]);
         end else if (iter) begin
            if (mb_q[0])
               acc_q <= acc_q + ma_q;
            ma_q <= ma_q << 1;
            mb_q <= mb_q >> 1;
         end
         // Sign is restored only once, on the magnitude product.
         if (fin)
            product_q <= neg_q ? -acc_q : acc_q;
         done_q <= fin;
      end
   end

endmodule

// File: tb/tb_seq_mult_sa.sv
// Bench for seq_mult_sa: one instance without and one with early exit, a vector
// table plus hand-written multi-cycle sequences, and a product scoreboard.
module tb_seq_mult_sa;

   localparam int W = 16;

   logic           clk, rst_n, sm, start0, start1;
   logic [W-1:0]   a, b;
   logic           busy0, done0, busy1, done1;
   logic [2*W-1:0] prod0, prod1;

   int checks   = 0;
   int failures = 0;

   logic [2*W-1:0] exp_q0[$];
   logic [2*W-1:0] exp_q1[$];
   logic           prev_done0 = 1'b0;
   logic           prev_done1 = 1'b0;

   typedef struct {
      logic           ee;
      logic           s;
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic [2*W-1:0] exp;
      int             lat;
   } vec_t;

   vec_t vecs[14];

   seq_mult_sa #(.W(W), .EARLY_EXIT(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .signed_mode(sm),
      .a(a), .b(b), .busy(busy0), .done(done0), .product(prod0)
   );

   seq_mult_sa #(.W(W), .EARLY_EXIT(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .signed_mode(sm),
      .a(a), .b(b), .busy(busy1), .done(done1), .product(prod1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   function automatic logic [2*W-1:0] model(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
      longint px, py;
      px = s ? longint'($signed(x)) : longint'(x);
      py = s ? longint'($signed(y)) : longint'(y);
      return (2*W)'(px * py);
   endfunction

   function automatic int lat_model(input logic ee, input logic s, input logic [W-1:0] y);
      logic [W-1:0] m;
      int n;
      if (!ee) return W + 1;
      m = (s && y[W-1]) ? W'(-y) : y;
      n = 1;
      for (int i = 0; i < W; i++)
         if (m[i]) n = i + 1;
      return n + 1;
   endfunction

   // Scoreboard: every done pops one expected product; done must be one cycle wide.
   always @(negedge clk) begin
      if (done0) begin
         check("done0_width", 64'(prev_done0), 64'd0);
         if (exp_q0.size() == 0) check("done0_spurious", 64'd1, 64'd0);
         else check("prod0", prod0, exp_q0.pop_front());
      end
      if (done1) begin
         check("done1_width", 64'(prev_done1), 64'd0);
         if (exp_q1.size() == 0) check("done1_spurious", 64'd1, 64'd0);
         else check("prod1", prod1, exp_q1.pop_front());
      end
      prev_done0 = done0;
      prev_done1 = done1;
   end

   task automatic issue(input int which, input logic s, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [2*W-1:0] e);
      sm = s;
      a  = x;
      b  = y;
      if (which == 0) begin
         start0 = 1'b1;
         exp_q0.push_back(e);
      end else begin
         start1 = 1'b1;
         exp_q1.push_back(e);
      end
      @(posedge clk);
      #1;
      start0 = 1'b0;
      start1 = 1'b0;
   endtask

   task automatic wait_done(input int which, input int exp_lat, input string name);
      int   lat = 0;
      int   bc;
      logic d = 1'b0;
      bc = ((which == 0) ? busy0 : busy1) ? 1 : 0;
      while (!d && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
         d = (which == 0) ? done0 : done1;
         if (!d && ((which == 0) ? busy0 : busy1)) bc++;
      end
      if (!d) begin
         check({name, "_timeout"}, 64'd0, 64'd1);
      end else begin
         check({name, "_latency"}, 64'(lat), 64'(exp_lat));
         check({name, "_busy_cycles"}, 64'(bc), 64'(exp_lat));
      end
   endtask

   initial begin
      rst_n  = 1'b1;
      start0 = 1'b0;
      start1 = 1'b0;
      sm     = 1'b0;
      a      = '0;
      b      = '0;
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy0", 64'(busy0), 64'd0);
      check("rst_done0", 64'(done0), 64'd0);
      check("rst_prod0", prod0, 64'd0);
      check("rst_busy1", 64'(busy1), 64'd0);
      check("rst_done1", 64'(done1), 64'd0);
      check("rst_prod1", prod1, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      vecs[0] = '{1'b0, 1'b0, 16'd17,    16'd5,    32'h0000_0055, 17};
      vecs[1] = '{1'b0, 1'b1, 16'hFFFD,  16'd7,    32'hFFFF_FFEB, 17};
      vecs[2] = '{1'b0, 1'b0, 16'hFFFD,  16'd7,    32'h0006_FFEB, 17};
      vecs[3] = '{1'b0, 1'b1, 16'h8000,  16'h8000, 32'h4000_0000, 17};
      vecs[4] = '{1'b0, 1'b0, 16'hFFFF,  16'hFFFF, 32'hFFFE_0001, 17};
      vecs[5] = '{1'b1, 1'b0, 16'd1234,  16'd0,    32'd0,         2};
      vecs[6] = '{1'b1, 1'b0, 16'd1234,  16'd5,    32'd6170,      4};
      vecs[7] = '{1'b1, 1'b1, 16'hFFFD,  16'd7,    32'hFFFF_FFEB, 4};
      vecs[8] = '{1'b1, 1'b1, 16'd5,     16'hFFFF, 32'hFFFF_FFFB, 2};
      vecs[9] = '{1'b1, 1'b1, 16'h8000,  16'h8000, 32'h4000_0000, 17};
      for (int i = 10; i < 14; i++) begin
         vecs[i].ee  = 1'($urandom_range(0, 1));
         vecs[i].s   = 1'($urandom_range(0, 1));
         vecs[i].a   = W'($urandom_range(0, 65535));
         vecs[i].b   = W'($urandom_range(0, 65535) >> $urandom_range(0, 15));
         vecs[i].exp = model(vecs[i].s, vecs[i].a, vecs[i].b);
         vecs[i].lat = lat_model(vecs[i].ee, vecs[i].s, vecs[i].b);
      end

      for (int i = 0; i < 14; i++) begin
         issue(int'(vecs[i].ee), vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].exp);
         wait_done(int'(vecs[i].ee), vecs[i].lat, $sformatf("vec%0d", i));
         @(negedge clk);
      end

      // start mid-CALC with other operands must be ignored
      issue(0, 1'b0, 16'd100, 16'd3, 32'd300);
      repeat (5) @(posedge clk);
      #1;
      a      = 16'd7;
      b      = 16'd7;
      sm     = 1'b1;
      start0 = 1'b1;
      @(posedge clk);
      #1;
      start0 = 1'b0;
      wait_done(0, 11, "ignore_start");
      repeat (25) @(negedge clk);

      // start held in the done cycle begins the next operation
      issue(0, 1'b0, 16'd200, 16'd2, 32'd400);
      wait_done(0, 17, "b2b_first");
      issue(0, 1'b1, 16'hFFF0, 16'd3, 32'hFFFF_FFD0);
      check("product_hold", prod0, 64'd400);
      wait_done(0, 17, "b2b_second");
      @(negedge clk);

      // asynchronous reset mid-CALC aborts with no done
      issue(0, 1'b0, 16'd1000, 16'd1000, 32'd1000000);
      repeat (4) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("abort_busy", 64'(busy0), 64'd0);
      check("abort_done", 64'(done0), 64'd0);
      check("abort_prod", prod0, 64'd0);
      exp_q0.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      issue(0, 1'b0, 16'd9, 16'd9, 32'd81);
      wait_done(0, 17, "after_reset");

      repeat (5) @(negedge clk);
      check("q0_drained", 64'(exp_q0.size()), 64'd0);
      check("q1_drained", 64'(exp_q1.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
